// File: rtl/io_pkg.sv
// Shared definitions for the serial output shifters: FSM encoding and
// legal parameter ranges.
package io_pkg;

  // One-hot FSM state encoding.
  typedef enum logic [3:0] {
    ST_CLEAR = 4'b0001,
    ST_IDLE  = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_LATCH = 4'b1000
  } state_t;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 64;
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 255;

  // True when the frame width and clock divider are inside the supported range.
  function automatic bit params_ok(input int width, input int clk_div);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (clk_div >= CLK_DIV_MIN) && (clk_div <= CLK_DIV_MAX);
  endfunction

endpackage

// File: rtl/serial_shift_out_tick_gen.sv
// Phase timer: emits a one-cycle tick on the last cycle of every CLK_DIV-cycle
// phase. A stored count of zero means "first cycle of a phase", so the reset
// value and the reload value coincide.
module tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_reload,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] C_DIV = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cur;

  assign w_cur  = (r_cnt == '0) ? C_DIV : r_cnt;
  assign o_tick = (w_cur == C_ONE);

  // Down-count through the phase; restart on tick or on an FSM state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_reload || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cur - C_ONE;
    end
  end

endmodule

// File: rtl/serial_shift_out.sv
// Parallel-to-serial shifter for external shift-register devices (7-seg, LED).
// Clears the device, shifts a WIDTH-bit frame on sclk/sdo, then pulses pen.
module serial_shift_out
  import io_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 8,
  parameter int LSB_FIRST = 0,
  parameter int AUTO      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdo,
  output logic             pen,
  output logic             sclr,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] SAT_BIT  = BW'(WIDTH);
  localparam logic [BW-1:0] ONE_BIT  = BW'(1);

  if (!params_ok(WIDTH, CLK_DIV)) begin : g_bad_params
    $error("serial_shift_out: WIDTH or CLK_DIV out of range");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_tick;
  logic             w_chg;
  logic             w_load;
  logic [WIDTH-1:0] r_shadow;
  logic [BW-1:0]    r_bit;
  logic             r_phase;
  logic             r_sdo;
  logic             r_from_latch;

  // Bit n of the frame in transmission order.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [BW-1:0] n);
    logic [WIDTH-1:0] t;
    if (LSB_FIRST != 0) begin
      t = w >> n;
      return t[0];
    end else begin
      t = w << n;
      return t[WIDTH-1];
    end
  endfunction

  assign w_load = (r_state == ST_IDLE) && valid;
  assign w_chg  = (w_next != r_state);

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_reload(w_chg),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b1;
    sclk   = 1'b0;
    pen    = 1'b0;
    sclr   = 1'b1;
    done   = 1'b0;
    sdo    = r_sdo;
    case (r_state)
      ST_CLEAR: begin
        sclr = 1'b0;
        if (w_tick) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        done  = r_from_latch;
        if (w_load || (AUTO != 0)) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        sclk = r_phase;
        if (w_tick && r_phase && (r_bit == LAST_BIT)) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        pen = 1'b1;
        if (w_tick) w_next = ST_IDLE;
      end
      default: begin
        sclr   = 1'b0;
        w_next = ST_CLEAR;
      end
    endcase
  end

  // Frame datapath: shadow capture, bit/phase counters and the sdo register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_bit        <= '0;
      r_phase      <= 1'b0;
      r_sdo        <= 1'b0;
      r_from_latch <= 1'b0;
    end else begin
      r_from_latch <= (r_state == ST_LATCH) && (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_bit   <= '0;
          r_phase <= 1'b0;
          if (w_load) r_shadow <= pdata;
          // First bit goes out with the entry into SHIFT; a fresh load wins over the shadow.
          if (w_next == ST_SHIFT) r_sdo <= bit_at(w_load ? pdata : r_shadow, '0);
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_bit != SAT_BIT) r_bit <= r_bit + ONE_BIT;
              // After the final bit sdo holds its value through LATCH.
              if (r_bit != LAST_BIT) r_sdo <= bit_at(r_shadow, r_bit + ONE_BIT);
            end
          end
        end
        default: begin
          r_bit   <= '0;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed bench: MSB-first, LSB-first and AUTO instances at WIDTH=16, CLK_DIV=2.
module tb_serial_shift_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  vld;
  logic [15:0] pd [3];
  logic [2:0]  rdy, sck, sd, pn, scl, bsy, dn;

  int vectors     = 0;
  int miscompares = 0;

  serial_shift_out #(.WIDTH(16), .CLK_DIV(2), .LSB_FIRST(0), .AUTO(0)) u_msb (
    .clk(clk), .rst(rst[0]), .pdata(pd[0]), .valid(vld[0]), .ready(rdy[0]), .sclk(sck[0]),
    .sdo(sd[0]), .pen(pn[0]), .sclr(scl[0]), .busy(bsy[0]), .done(dn[0]));

  serial_shift_out #(.WIDTH(16), .CLK_DIV(2), .LSB_FIRST(1), .AUTO(0)) u_lsb (
    .clk(clk), .rst(rst[1]), .pdata(pd[1]), .valid(vld[1]), .ready(rdy[1]), .sclk(sck[1]),
    .sdo(sd[1]), .pen(pn[1]), .sclr(scl[1]), .busy(bsy[1]), .done(dn[1]));

  serial_shift_out #(.WIDTH(16), .CLK_DIV(2), .LSB_FIRST(0), .AUTO(1)) u_auto (
    .clk(clk), .rst(rst[2]), .pdata(pd[2]), .valid(vld[2]), .ready(rdy[2]), .sclk(sck[2]),
    .sdo(sd[2]), .pen(pn[2]), .sclr(scl[2]), .busy(bsy[2]), .done(dn[2]));

  // {sclk, sdo, pen, sclr, ready, busy, done} of instance d
  function automatic logic [6:0] outs(input int d);
    return {sck[d], sd[d], pn[d], scl[d], rdy[d], bsy[d], dn[d]};
  endfunction

  // Observe one frame from the cycle after capture until the first non-busy sample.
  task automatic watch(input int d, input bit scramble, output logic [15:0] rx,
                       output int rises, output int pen_cyc, output int pen_pulses,
                       output int busy_cyc, output int errs, output bit done_seen);
    logic ps, pp, psd;
    rx = '0; rises = 0; pen_cyc = 0; pen_pulses = 0; busy_cyc = 0; errs = 0;
    done_seen = 1'b0; ps = 1'b0; pp = 1'b0; psd = sd[d];
    for (int c = 0; c < 400 && !done_seen; c++) begin
      @(negedge clk);
      if (!bsy[d]) begin
        done_seen = 1'b1;
        if (dn[d] !== 1'b1 || rdy[d] !== 1'b1) errs++;
      end else begin
        busy_cyc++;
        if (dn[d] !== 1'b0 || rdy[d] !== 1'b0 || scl[d] !== 1'b1) errs++;
        if (sck[d] && !ps) begin
          rises++;
          rx = {rx[14:0], sd[d]};
          if (sd[d] !== psd) errs++;
        end
        if (pn[d]) begin
          pen_cyc++;
          if (!pp) pen_pulses++;
          if (sck[d] !== 1'b0 || sd[d] !== rx[0]) errs++;
        end
        ps = sck[d]; pp = pn[d]; psd = sd[d];
        if (scramble) pd[d] = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 3'b111; vld = 3'b000;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (outs(d) !== 7'b0000010) begin
        miscompares++;
        $display("FAIL reset_outs[%0d]: got %b want 0000010", d, outs(d));
      end
    end
    @(posedge clk); #1 rst[1:0] = 2'b00;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({scl[d], bsy[d], rdy[d]} !== ((s < 2) ? 3'b010 : 3'b101)) begin
          miscompares++;
          $display("FAIL clear_seq[%0d] cycle %0d: sclr/busy/ready got %b want %b",
                   d, s, {scl[d], bsy[d], rdy[d]}, (s < 2) ? 3'b010 : 3'b101);
        end
      end
    end
  endtask

  task automatic test_frame(input int d, input logic [15:0] word, input logic [15:0] exp_rx);
    logic [15:0] rx; int r, pc, pp, bc, er; bit ds;
    @(negedge clk);
    vectors++;
    if (rdy[d] !== 1'b1) begin
      miscompares++; $display("FAIL frame_ready[%0d]: got %b want 1", d, rdy[d]);
    end
    pd[d] = word; vld[d] = 1'b1;
    @(posedge clk); #1 vld[d] = 1'b0; pd[d] = 16'hFFFF;
    watch(d, 1'b0, rx, r, pc, pp, bc, er, ds);
    vectors++;
    if (ds !== 1'b1) begin miscompares++; $display("FAIL frame_timeout[%0d]: done_seen %b want 1", d, ds); end
    vectors++;
    if (rx !== exp_rx) begin miscompares++; $display("FAIL frame_data[%0d]: got %h want %h", d, rx, exp_rx); end
    vectors++;
    if (r != 16) begin miscompares++; $display("FAIL frame_rises[%0d]: got %0d want 16", d, r); end
    vectors++;
    if (pc != 2 || pp != 1) begin
      miscompares++; $display("FAIL frame_pen[%0d]: cycles %0d pulses %0d want 2/1", d, pc, pp);
    end
    vectors++;
    if (bc != 66) begin miscompares++; $display("FAIL frame_busy[%0d]: got %0d want 66", d, bc); end
    vectors++;
    if (er != 0) begin miscompares++; $display("FAIL frame_protocol[%0d]: got %0d errors want 0", d, er); end
    @(negedge clk);
    vectors++;
    if ({dn[d], rdy[d], bsy[d]} !== 3'b010) begin
      miscompares++; $display("FAIL frame_done_pulse[%0d]: done/ready/busy got %b want 010", d, {dn[d], rdy[d], bsy[d]});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx; int r, pc, pp, bc, er; bit ds;
    @(negedge clk);
    pd[0] = 16'hA5C3; vld[0] = 1'b1;
    @(posedge clk); #1;
    watch(0, 1'b1, rx, r, pc, pp, bc, er, ds);
    vectors++;
    if (ds !== 1'b1 || rx !== 16'hA5C3 || bc != 66 || er != 0) begin
      miscompares++;
      $display("FAIL b2b_first: data %h busy %0d errs %0d done %b want a5c3/66/0/1", rx, bc, er, ds);
    end
    pd[0] = 16'h3C5A;
    watch(0, 1'b1, rx, r, pc, pp, bc, er, ds);
    vld[0] = 1'b0;
    vectors++;
    if (ds !== 1'b1 || rx !== 16'h3C5A || bc != 66 || r != 16 || er != 0) begin
      miscompares++;
      $display("FAIL b2b_second: data %h busy %0d rises %0d errs %0d want 3c5a/66/16/0", rx, bc, r, er);
    end
    @(negedge clk);
    vectors++;
    if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      miscompares++; $display("FAIL b2b_idle: busy/ready got %b%b want 01", bsy[0], rdy[0]);
    end
  endtask

  task automatic test_reset_mid();
    int r; bit pen_seen; logic ps;
    r = 0; pen_seen = 1'b0; ps = 1'b0;
    @(negedge clk);
    pd[0] = 16'hA5C3; vld[0] = 1'b1;
    @(posedge clk); #1 vld[0] = 1'b0;
    for (int c = 0; c < 200 && r < 7; c++) begin
      @(negedge clk);
      if (sck[0] && !ps) r++;
      if (pn[0]) pen_seen = 1'b1;
      ps = sck[0];
    end
    vectors++;
    if (r != 7) begin miscompares++; $display("FAIL mid_rises: got %0d want 7", r); end
    rst[0] = 1'b1;
    #1;
    vectors++;
    if (outs(0) !== 7'b0000010) begin
      miscompares++; $display("FAIL mid_reset_outs: got %b want 0000010", outs(0));
    end
    @(posedge clk); #1 rst[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (pn[0]) pen_seen = 1'b1;
      vectors++;
      if ({scl[0], bsy[0], rdy[0]} !== ((s < 2) ? 3'b010 : 3'b101)) begin
        miscompares++;
        $display("FAIL mid_clear_seq cycle %0d: sclr/busy/ready got %b want %b",
                 s, {scl[0], bsy[0], rdy[0]}, (s < 2) ? 3'b010 : 3'b101);
      end
    end
    vectors++;
    if (pen_seen !== 1'b0) begin miscompares++; $display("FAIL mid_pen: got pulse want none"); end
  endtask

  task automatic test_auto();
    logic [15:0] rx; int r, pc, pp, bc, er; bit ds;
    pd[2] = 16'h0001; vld[2] = 1'b1;
    @(posedge clk); #1 rst[2] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rdy[2] !== 1'b1 || scl[2] !== 1'b1) begin
      miscompares++; $display("FAIL auto_idle: ready/sclr got %b%b want 11", rdy[2], scl[2]);
    end
    @(posedge clk); #1 vld[2] = 1'b0; pd[2] = 16'hFFFF;
    for (int f = 0; f < 2; f++) begin
      watch(2, 1'b0, rx, r, pc, pp, bc, er, ds);
      vectors++;
      if (ds !== 1'b1 || rx !== 16'h0001 || r != 16) begin
        miscompares++;
        $display("FAIL auto_frame%0d_data: data %h rises %0d done %b want 0001/16/1", f, rx, r, ds);
      end
      vectors++;
      if (pp != 1 || pc != 2 || bc != 66 || er != 0) begin
        miscompares++;
        $display("FAIL auto_frame%0d_timing: pulses %0d pen %0d busy %0d errs %0d want 1/2/66/0",
                 f, pp, pc, bc, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 16'hA5C3, 16'hA5C3);
    test_frame(1, 16'hA5C3, 16'hC3A5);
    test_back_to_back();
    test_reset_mid();
    test_auto();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_shift_out.md
SERIAL_SHIFT_OUT -- requirements
Module: serial_shift_out

Interface
REQ-001 Parameter WIDTH, default 16: number of bits shifted per frame, legal range 2..64.
REQ-002 Parameter CLK_DIV, default 8: clk cycles per sclk half-period, legal range 1..255.
REQ-003 Parameter LSB_FIRST, default 0: 0 shifts pdata[WIDTH-1] first, 1 shifts pdata[0] first.
REQ-004 Parameter AUTO, default 0: 1 repeats the stored frame back-to-back without a new load.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pdata  input  WIDTH  parallel word to be shifted.
REQ-008 valid  input  1  load request; pdata is captured when valid and ready are both high at a clk edge.
REQ-009 ready  output  1  high only in IDLE; block accepts a load.
REQ-010 sclk  output  1  serial shift clock, idle low.
REQ-011 sdo  output  1  serial data, stable across every sclk rising edge.
REQ-012 pen  output  1  active-high latch pulse to the external register after the last bit.
REQ-013 sclr  output  1  active-low clear to the external register.
REQ-014 busy  output  1  high in CLEAR, SHIFT and LATCH.
REQ-015 done  output  1  one-cycle pulse on the first IDLE cycle after LATCH.

Function
REQ-016 States: CLEAR, IDLE, SHIFT, LATCH; encoding is one-hot.
REQ-017 CLEAR holds sclr low for CLK_DIV cycles, then goes to IDLE; sclr is high in every other state.
REQ-018 IDLE -> SHIFT on valid&&ready; pdata goes into a WIDTH-bit shadow register on the same edge.
REQ-019 AUTO=1: IDLE -> SHIFT one cycle after entry even with valid low; the shadow word is resent; a valid in that cycle wins and overwrites the shadow.
REQ-020 SHIFT: each bit is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; sdo updates only at the start of each low phase.
REQ-021 SHIFT emits exactly WIDTH sclk rising edges, bit order per LSB_FIRST; a bit counter of width clog2(WIDTH+1) saturates and never wraps.
REQ-022 LATCH: sclk low, sdo holds the last bit, pen high for exactly CLK_DIV cycles, then IDLE.
REQ-023 busy is high for exactly 2*CLK_DIV*WIDTH+CLK_DIV cycles per frame, counted from the cycle after the capture edge.
REQ-024 valid while busy is ignored and never queued; pdata changes while busy do not affect the frame in flight.
REQ-025 No combinational path from valid or pdata to any output.

Reset
REQ-026 rst asserted at any time, including mid-frame, forces CLEAR immediately: sclk=0, sdo=0, pen=0, sclr=0, ready=0, busy=1, done=0, shadow=0, counters=0.
REQ-027 After rst deasserts, the full CLEAR sequence (REQ-017) runs before ready rises.

Structure
REQ-028 The state encoding and the CLK_DIV/WIDTH range-check constants belong in the shared package io_pkg.
REQ-029 One sub-module, tick_gen: a parametrised CLK_DIV down-counter producing a one-cycle phase tick; it is reloaded on every state change.
REQ-030 The block instantiates once per serial device: 7-seg, LED and future extensions.

Verification (WIDTH=16, CLK_DIV=2 unless noted)
REQ-031 Release rst -> sclr low for 2 cycles, then ready=1; busy=1 throughout CLEAR.
REQ-032 Load 16'hA5C3, LSB_FIRST=0 -> sdo at the 16 sclk rises reads 1010_0101_1100_0011; pen high 2 cycles; busy high 66 cycles; done one pulse.
REQ-033 Same load, LSB_FIRST=1 -> sdo reads 1100_0011_1010_0101.
REQ-034 valid held high with pdata changing during the frame -> shifted data is still 16'hA5C3; the next frame starts the cycle after done.
REQ-035 rst asserted after 7 sclk rises -> all outputs at reset values next sample; pen is never pulsed; CLEAR reruns.
REQ-036 AUTO=1, one load of 16'h0001 -> frames repeat with one IDLE cycle between LATCH and SHIFT; each frame has 16 sclk rises and one pen pulse.
